// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a mid-bit sampling receiver and a FIFO-fed transmitter.
module uart_core #(
    parameter int CLKS_PER_BIT  = 234,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             uart_rx,
    output logic                             uart_tx,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx_busy,
    output logic [$clog2(TX_FIFO_DEPTH):0]   tx_level,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    output logic                             rx_parity_err,
    output logic                             rx_frame_err
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

    rx_state_t rx_state, rx_next;
    logic rx_meta, rx_s, rx_par, rx_tick;
    logic [CW-1:0] rx_cnt;
    logic [BW-1:0] rx_bit;
    logic [DATA_BITS-1:0] rx_sh;

    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_meta, rx_s} <= 2'b11;
        else {rx_meta, rx_s} <= {uart_rx, rx_meta};

    // start bit is probed at half a bit, every later sample one full bit apart
    assign rx_tick = rx_cnt == (rx_state == R_START ? HALF_END : BIT_END);

    always_ff @(posedge clk or posedge rst)
        if (rst) rx_state <= R_IDLE;
        else rx_state <= rx_next;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:   if (!rx_s) rx_next = R_START;
            R_START:  if (rx_tick) rx_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_next = PARITY != 0 ? R_PARITY : R_STOP;
            R_PARITY: if (rx_tick) rx_next = R_STOP;
            R_STOP:   if (rx_tick) rx_next = rx_s ? R_IDLE : R_WAIT;
            R_WAIT:   if (rx_s) rx_next = R_IDLE;
            default:  rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_par <= 1'b0;
            rx_data <= '0; rx_valid <= 1'b0; rx_parity_err <= 1'b0; rx_frame_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_cnt <= (rx_state == R_IDLE || rx_state == R_WAIT || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == R_START) rx_bit <= '0;
            if (rx_tick && rx_state == R_DATA) begin
                rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            if (rx_tick && rx_state == R_PARITY) rx_par <= rx_s;
            if (rx_tick && rx_state == R_STOP) begin
                rx_valid <= 1'b1;
                rx_data <= rx_sh;
                rx_frame_err <= !rx_s;
                rx_parity_err <= PARITY == 1 ? !(^rx_sh ^ rx_par) : PARITY == 2 ? (^rx_sh ^ rx_par) : 1'b0;
            end
        end

    tx_state_t tx_state, tx_next;
    logic [DATA_BITS-1:0] fifo [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] tx_cnt;
    logic [BW-1:0] tx_bit;
    logic [DATA_BITS-1:0] tx_sh;
    logic tx_par, tx_tick, push, pop, tx_line, fifo_empty;

    assign fifo_empty = tx_level == '0;
    assign tx_ready = !tx_level[AW];
    assign push = tx_valid && tx_ready;
    assign tx_tick = tx_cnt == (tx_state == T_STOP ? STOP_END : BIT_END);
    assign pop = !fifo_empty && (tx_state == T_IDLE || (tx_state == T_STOP && tx_tick));
    assign tx_line = tx_state == T_START ? 1'b0 : tx_state == T_DATA ? tx_sh[0] : tx_state == T_PARITY ? tx_par : 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) tx_state <= T_IDLE;
        else tx_state <= tx_next;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:   if (!fifo_empty) tx_next = T_START;
            T_START:  if (tx_tick) tx_next = T_DATA;
            T_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_next = PARITY != 0 ? T_PARITY : T_STOP;
            T_PARITY: if (tx_tick) tx_next = T_STOP;
            T_STOP:   if (tx_tick) tx_next = fifo_empty ? T_IDLE : T_START;
            default:  tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= tx_data;

    // uart_tx and tx_busy are registered, so both trail the FSM state by one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0; rd_ptr <= '0; tx_level <= '0; tx_cnt <= '0; tx_bit <= '0;
            tx_sh <= '0; tx_par <= 1'b0; uart_tx <= 1'b1; tx_busy <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            tx_level <= tx_level + LW'(push) - LW'(pop);
            tx_cnt <= (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (pop) begin
                tx_sh <= fifo[rd_ptr];
                tx_par <= (PARITY == 1) ^ (^fifo[rd_ptr]);
                tx_bit <= '0;
            end else if (tx_tick && tx_state == T_DATA) begin
                tx_sh <= tx_sh >> 1;
                tx_bit <= tx_bit + 1'b1;
            end
            uart_tx <= tx_line;
            tx_busy <= tx_state != T_IDLE || !fifo_empty;
        end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core; one 8N1 instance and one 8E1 instance at 16 clocks per bit.
module tb_uart_core;
    localparam int C = 16;
    typedef struct {logic [7:0] d; logic pe; logic fe;} rx_t;

    logic clk = 0, rst = 1;
    logic rn_line = 1, re_line = 1;
    logic [7:0] tn_data = 0, te_data = 0;
    logic tn_valid = 0, te_valid = 0;
    logic n_tx, n_ready, n_busy, n_rx_valid, n_perr, n_ferr;
    logic e_tx, e_ready, e_busy, e_rx_valid, e_perr, e_ferr;
    logic [2:0] n_level, e_level;
    logic [7:0] n_rx_data, e_rx_data;
    int checks = 0, errors = 0, cyc = 0, stalls = 0;
    int n_rx_cnt = 0, e_rx_cnt = 0, n_last = 0, e_last = 0;
    logic [7:0] tx_exp[$];
    int tx_starts[$];
    rx_t rxq_n[$], rxq_e[$];

    uart_core #(.CLKS_PER_BIT(C), .PARITY(0)) u_n (
        .clk(clk), .rst(rst), .uart_rx(rn_line), .uart_tx(n_tx),
        .tx_data(tn_data), .tx_valid(tn_valid), .tx_ready(n_ready), .tx_busy(n_busy), .tx_level(n_level),
        .rx_data(n_rx_data), .rx_valid(n_rx_valid), .rx_parity_err(n_perr), .rx_frame_err(n_ferr)
    );

    uart_core #(.CLKS_PER_BIT(C), .PARITY(2)) u_e (
        .clk(clk), .rst(rst), .uart_rx(re_line), .uart_tx(e_tx),
        .tx_data(te_data), .tx_valid(te_valid), .tx_ready(e_ready), .tx_busy(e_busy), .tx_level(e_level),
        .rx_data(e_rx_data), .rx_valid(e_rx_valid), .rx_parity_err(e_perr), .rx_frame_err(e_ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (e) re_line = bits[i];
            else rn_line = bits[i];
            step(C);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        tn_data = b;
        tn_valid = 1;
        while (!n_ready && t < 4000) begin
            stalls++;
            check("level_at_stall", n_level, 4);
            step(1);
            t++;
        end
        check("push_accepted", n_ready, 1);
        step(1);
        tx_exp.push_back(b);
    endtask

    // serial decoder on the 8N1 transmitter; frames overlapped by reset are discarded
    initial begin : tx_mon
        logic [7:0] b;
        logic ab;
        int t0;
        forever begin
            @(negedge clk);
            if (!rst && n_tx === 1'b0) begin
                t0 = cyc;
                ab = 0;
                for (int o = 1; o <= 9 * C + C / 2; o++) begin
                    @(negedge clk);
                    ab |= rst;
                    if (o % C == C / 2 && o > C && o < 9 * C) b[o / C - 1] = n_tx;
                end
                if (!ab) begin
                    tx_starts.push_back(t0);
                    check("tx_stop", n_tx, 1);
                    check("tx_pending", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) check("tx_data", b, tx_exp.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (n_rx_valid) begin
            n_rx_cnt++;
            n_last = cyc;
            check("rxn_pending", rxq_n.size() != 0, 1);
            if (rxq_n.size() != 0) begin
                check("rxn_data", n_rx_data, rxq_n[0].d);
                check("rxn_perr", n_perr, rxq_n[0].pe);
                check("rxn_ferr", n_ferr, rxq_n[0].fe);
                void'(rxq_n.pop_front());
            end
        end
        if (e_rx_valid) begin
            e_rx_cnt++;
            e_last = cyc;
            check("rxe_pending", rxq_e.size() != 0, 1);
            if (rxq_e.size() != 0) begin
                check("rxe_data", e_rx_data, rxq_e[0].d);
                check("rxe_perr", e_perr, rxq_e[0].pe);
                check("rxe_ferr", e_ferr, rxq_e[0].fe);
                void'(rxq_e.pop_front());
            end
        end
    end

    initial begin
        int k, t, t0;
        step(3);
        check("rst_tx", n_tx, 1);
        check("rst_ready", n_ready, 1);
        check("rst_busy", n_busy, 0);
        check("rst_level", n_level, 0);
        check("rst_rx_data", n_rx_data, 0);
        check("rst_rx_valid", n_rx_valid, 0);
        check("rst_perr", n_perr, 0);
        check("rst_ferr", n_ferr, 0);
        rst = 0;
        step(5);

        push(8'h55);
        tn_valid = 0;
        k = cyc;
        step(1);
        check("tx_pre_start", n_tx, 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("tx_bit_first", n_tx, i % 2);
            step(C - 1);
            check("tx_bit_last", n_tx, i % 2);
        end
        check("busy_in_stop", n_busy, 1);
        step(1);
        check("busy_after_stop", n_busy, 0);
        check("idle_after_stop", n_tx, 1);
        check("tx_drain_55", tx_exp.size(), 0);
        check("tx_frames_55", tx_starts.size(), 1);
        check("tx_start_latency", tx_starts.size() != 0 ? tx_starts[0] - k : -1, 2);

        tx_starts.delete();
        stalls = 0;
        for (int i = 1; i <= 6; i++) push(8'(i));
        tn_valid = 0;
        t = 0;
        while (tx_exp.size() != 0 && t < 3000) begin step(1); t++; end
        check("burst_drained", tx_exp.size(), 0);
        step(20);
        check("burst_level", n_level, 0);
        check("burst_busy", n_busy, 0);
        check("burst_stalled", stalls != 0, 1);
        check("burst_frames", tx_starts.size(), 6);
        for (int i = 1; i < tx_starts.size(); i++) check("burst_gap", tx_starts[i] - tx_starts[i - 1], 10 * C);

        rxq_e.push_back('{8'hA3, 1'b0, 1'b0});
        rxq_e.push_back('{8'hA3, 1'b1, 1'b0});
        t0 = cyc;
        drive(1, {5'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
        check("rx_latency_8e1", e_last - t0, 2 + C / 2 + 10 * C + 1);
        drive(1, {5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
        step(C);
        check("rxe_drained", rxq_e.size(), 0);
        check("rxe_count", e_rx_cnt, 2);

        rxq_n.push_back('{8'h3C, 1'b0, 1'b1});
        drive(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        check("break_frame_seen", n_rx_cnt, 1);
        step(40 * C);
        check("break_no_extra", n_rx_cnt, 1);
        rn_line = 1;
        step(2 * C);
        rxq_n.push_back('{8'h81, 1'b0, 1'b0});
        t0 = cyc;
        drive(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
        check("rx_latency_8n1", n_last - t0, 2 + C / 2 + 9 * C + 1);
        check("rxn_count_break", n_rx_cnt, 2);

        rn_line = 0;
        step(4);
        rn_line = 1;
        step(10);
        check("glitch_no_valid", n_rx_cnt, 2);
        rxq_n.push_back('{8'h5A, 1'b0, 1'b0});
        drive(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        step(C);
        check("glitch_then_frame", n_rx_cnt, 3);
        check("rxn_drained", rxq_n.size(), 0);

        push(8'hA5);
        k = cyc;
        push(8'h11);
        push(8'h22);
        tn_valid = 0;
        step(k + 70 - cyc);
        check("pre_reset_line", n_tx, 0);
        check("pre_reset_level", n_level, 2);
        rst = 1;
        #1;
        check("mid_rst_tx", n_tx, 1);
        check("mid_rst_level", n_level, 0);
        check("mid_rst_ready", n_ready, 1);
        check("mid_rst_busy", n_busy, 0);
        tx_exp.delete();
        step(3);
        rst = 0;
        step(200);
        push(8'hF0);
        tn_valid = 0;
        t = 0;
        while (tx_exp.size() != 0 && t < 1000) begin step(1); t++; end
        check("post_rst_drained", tx_exp.size(), 0);
        step(20);
        check("post_rst_level", n_level, 0);
        check("post_rst_busy", n_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
